// File: rtl/enigma_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | enigma_stream_ctrl                                                       |
// | ASCII byte-stream front end that sequences a three-rotor Enigma core.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module enigma_stream_ctrl #(
    parameter logic PASS_NONALPHA = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [4:0]  cfg_pos_r1,
    input  logic [4:0]  cfg_pos_r2,
    input  logic [4:0]  cfg_pos_r3,
    output logic        cfg_ready,
    output logic        cfg_err,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        core_load,
    output logic [4:0]  core_pos_r1,
    output logic [4:0]  core_pos_r2,
    output logic [4:0]  core_pos_r3,
    output logic        core_step,
    output logic [4:0]  core_char,
    input  logic [4:0]  core_char_out,
    output logic [15:0] char_count
);

    typedef enum logic [2:0] {
        S_UNCFG = 3'd0,
        S_READY = 3'd1,
        S_STEP  = 3'd2,
        S_ENC   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [7:0] c_ASCII_A = 8'h41;
    localparam logic [7:0] c_ASCII_LA = 8'h61;

    state_t      r_state;
    logic        r_cfg_err;
    logic        r_core_load;
    logic [4:0]  r_pos_r1;
    logic [4:0]  r_pos_r2;
    logic [4:0]  r_pos_r3;
    logic [4:0]  r_idx;
    logic [7:0]  r_out_data;
    logic [15:0] r_char_count;

    logic        w_cfg_ready;
    logic        w_in_ready;
    logic        w_cfg_accept;
    logic        w_cfg_legal;
    logic        w_byte_accept;
    logic        w_is_upper;
    logic        w_is_lower;
    logic [4:0]  w_idx;

    assign w_cfg_ready   = (r_state == S_UNCFG) || (r_state == S_READY);
    // A pending config always takes priority over a pending byte.
    assign w_in_ready    = (r_state == S_READY) && !cfg_valid;
    assign w_cfg_accept  = cfg_valid && w_cfg_ready;
    assign w_cfg_legal   = (cfg_pos_r1 <= 5'd25) && (cfg_pos_r2 <= 5'd25) && (cfg_pos_r3 <= 5'd25);
    assign w_byte_accept = in_valid && w_in_ready;
    assign w_is_upper    = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign w_is_lower    = (in_data >= 8'h61) && (in_data <= 8'h7A);
    assign w_idx         = w_is_upper ? 5'(in_data - c_ASCII_A) : 5'(in_data - c_ASCII_LA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_UNCFG;
            r_cfg_err    <= 1'b0;
            r_core_load  <= 1'b0;
            r_pos_r1     <= 5'd0;
            r_pos_r2     <= 5'd0;
            r_pos_r3     <= 5'd0;
            r_idx        <= 5'd0;
            r_out_data   <= 8'h00;
            r_char_count <= 16'd0;
        end else begin
            r_cfg_err   <= 1'b0;
            r_core_load <= 1'b0;
            case (r_state)
                S_UNCFG, S_READY: begin
                    if (w_cfg_accept) begin
                        if (w_cfg_legal) begin
                            r_pos_r1     <= cfg_pos_r1;
                            r_pos_r2     <= cfg_pos_r2;
                            r_pos_r3     <= cfg_pos_r3;
                            r_core_load  <= 1'b1;
                            r_char_count <= 16'd0;
                            r_state      <= S_READY;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end else if (w_byte_accept) begin
                        if (w_is_upper || w_is_lower) begin
                            r_idx   <= w_idx;
                            r_state <= S_STEP;
                        end else if (PASS_NONALPHA) begin
                            r_out_data <= in_data;
                            r_state    <= S_OUT;
                        end
                    end
                end
                S_STEP: r_state <= S_ENC;
                // The rotors advanced at the S_STEP edge, so core_char_out is now valid.
                S_ENC: begin
                    r_out_data   <= c_ASCII_A + {3'b000, core_char_out};
                    r_char_count <= r_char_count + 16'd1;
                    r_state      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_READY;
                    end
                end
                default: r_state <= S_UNCFG;
            endcase
        end
    end

    assign cfg_ready   = w_cfg_ready;
    assign cfg_err     = r_cfg_err;
    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == S_OUT);
    assign out_data    = r_out_data;
    assign core_load   = r_core_load;
    assign core_pos_r1 = r_pos_r1;
    assign core_pos_r2 = r_pos_r2;
    assign core_pos_r3 = r_pos_r3;
    assign core_step   = (r_state == S_STEP);
    assign core_char   = r_idx;
    assign char_count  = r_char_count;

endmodule
`default_nettype wire
